// File: rtl/kp_pkg.sv
// Shared types, column/key constants and helpers for the 4x4 keypad scanner.
// The key map matches the wirecutter front-panel legend.
package kp_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;

    localparam logic [3:0] COL0     = 4'b0111;
    localparam logic [3:0] COL1     = 4'b1011;
    localparam logic [3:0] COL2     = 4'b1101;
    localparam logic [3:0] COL3     = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    localparam logic [3:0] KEY_STOP = 4'hA;
    localparam logic [3:0] KEY_GO   = 4'hB;
    localparam logic [3:0] KEY_LOCK = 4'hC;
    localparam logic [3:0] KEY_ENT  = 4'hD;
    localparam logic [3:0] KEY_ESC  = 4'hE;
    localparam logic [3:0] KEY_PWR  = 4'hF;

    // Exactly one row pulled low.
    function automatic logic kp_row_valid(input logic [3:0] rs);
        case (rs)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: kp_row_valid = 1'b1;
            default:                            kp_row_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] kp_next_col(input logic [3:0] col);
        kp_next_col = {col[0], col[3:1]};
    endfunction

    function automatic logic [1:0] kp_idx(input logic [3:0] v);
        case (v)
            4'b0111: kp_idx = 2'd0;
            4'b1011: kp_idx = 2'd1;
            4'b1101: kp_idx = 2'd2;
            4'b1110: kp_idx = 2'd3;
            default: kp_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] kp_map(input logic [3:0] kpc, input logic [3:0] kpr);
        case ({kp_idx(kpr), kp_idx(kpc)})
            4'd0:    kp_map = 4'h1;
            4'd1:    kp_map = 4'h2;
            4'd2:    kp_map = 4'h3;
            4'd3:    kp_map = KEY_STOP;
            4'd4:    kp_map = 4'h4;
            4'd5:    kp_map = 4'h5;
            4'd6:    kp_map = 4'h6;
            4'd7:    kp_map = KEY_GO;
            4'd8:    kp_map = 4'h7;
            4'd9:    kp_map = 4'h8;
            4'd10:   kp_map = 4'h9;
            4'd11:   kp_map = KEY_LOCK;
            4'd12:   kp_map = KEY_ENT;
            4'd13:   kp_map = 4'h0;
            4'd14:   kp_map = KEY_ESC;
            default: kp_map = KEY_PWR;
        endcase
    endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for the active-low row sense lines; resets to idle.
module kp_sync2
    import kp_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= ROW_IDLE;
            q    <= ROW_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/kpscan.sv
// 4x4 keypad scanner: one-cold column drive, debounced press/release,
// one key code per press delivered over valid/ready with sticky overrun.
module kpscan
    import kp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DB_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic       kphit,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [3:0] key_code,
    output logic       overrun
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DB_SCANS + 1);

    logic [3:0]    rs;
    logic [DW-1:0] dwell;
    logic [CW-1:0] dbcnt, dbcnt_n;
    logic [3:0]    cap, cap_n;
    logic [3:0]    kpc_n;
    kp_state_t     state, state_n;
    logic          kphit_n, kv_n, ov_n, emit, sample, xfer;
    logic [3:0]    kc_n;

    kp_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (kpr),
        .q       (rs)
    );

    assign sample = (dwell == DW'(SCAN_DIV - 1));
    assign xfer   = key_valid & key_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dwell <= '0;
        else          dwell <= sample ? '0 : dwell + DW'(1);
    end

    // Scan/debounce FSM; dbcnt serves as press count in DEBOUNCE and release count in HELD.
    always_comb begin
        state_n = state;
        kpc_n   = kpc;
        dbcnt_n = dbcnt;
        cap_n   = cap;
        kphit_n = kphit;
        emit    = 1'b0;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (kp_row_valid(rs)) begin
                        cap_n   = rs;
                        dbcnt_n = CW'(1);
                        state_n = DEBOUNCE;
                    end else begin
                        kpc_n = kp_next_col(kpc);
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (rs == cap) begin
                        if (dbcnt == CW'(DB_SCANS - 1)) begin
                            emit    = 1'b1;
                            kphit_n = 1'b1;
                            dbcnt_n = '0;
                            state_n = HELD;
                        end else begin
                            dbcnt_n = dbcnt + CW'(1);
                        end
                    end else begin
                        dbcnt_n = '0;
                        kpc_n   = kp_next_col(kpc);
                        state_n = SCAN;
                    end
                end
            end
            HELD: begin
                if (sample) begin
                    if (rs == ROW_IDLE) begin
                        if (dbcnt == CW'(DB_SCANS - 1)) begin
                            kphit_n = 1'b0;
                            dbcnt_n = '0;
                            kpc_n   = kp_next_col(kpc);
                            state_n = SCAN;
                        end else begin
                            dbcnt_n = dbcnt + CW'(1);
                        end
                    end else begin
                        dbcnt_n = '0;
                    end
                end
            end
            default: begin
                dbcnt_n = '0;
                state_n = SCAN;
            end
        endcase
    end

    // A transfer in the emit cycle frees the slot, so the new key loads without overrun.
    always_comb begin
        kv_n = key_valid;
        kc_n = key_code;
        ov_n = overrun;
        if (xfer) begin
            kv_n = 1'b0;
            ov_n = 1'b0;
        end
        if (emit) begin
            if (!key_valid || xfer) begin
                kv_n = 1'b1;
                kc_n = kp_map(kpc, cap);
            end else begin
                ov_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SCAN;
            kpc       <= COL0;
            dbcnt     <= '0;
            cap       <= ROW_IDLE;
            kphit     <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            kpc       <= kpc_n;
            dbcnt     <= dbcnt_n;
            cap       <= cap_n;
            kphit     <= kphit_n;
            key_valid <= kv_n;
            key_code  <= kc_n;
            overrun   <= ov_n;
        end
    end

endmodule

// File: tb/tb_kpscan.sv
// Bench for kpscan: a physical keypad model drives kpr from kpc; expected
// codes come from the legend table and timing from the dwell/debounce rules.
module tb_kpscan;

    localparam int SD  = 4;
    localparam int DB  = 3;
    localparam int LAT = SD * DB;          // kpc lands on column -> kphit/key_valid rise
    localparam int RLO = 3 + SD * (DB - 1); // release -> kphit fall, min
    localparam int RHI = 2 + SD * DB;       // release -> kphit fall, max

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] kpr, kpc, key_code;
    logic       kphit, key_valid, key_ready, overrun;

    logic       key_down = 1'b0;
    logic       raw_mode = 1'b0;
    logic [3:0] raw_val  = 4'hF;
    int         kr = 0, kc = 0;
    int         checks = 0, errors = 0;
    int         xfer_cnt = 0;
    logic [3:0] last_code = 4'h0;

    logic [3:0] colpat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [3:0] rowpat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [3:0] codes [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                 '{4'h4, 4'h5, 4'h6, 4'hB},
                                 '{4'h7, 4'h8, 4'h9, 4'hC},
                                 '{4'hD, 4'h0, 4'hE, 4'hF}};

    kpscan #(.SCAN_DIV(SD), .DB_SCANS(DB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .kpr       (kpr),
        .kpc       (kpc),
        .kphit     (kphit),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pressed key (kr,kc) pulls row kr low only while column kc is driven low.
    always_comb begin
        kpr = 4'hF;
        if (raw_mode) kpr = raw_val;
        else if (key_down && kpc == colpat[kc]) kpr = rowpat[kr];
    end

    always @(posedge clk) begin
        if (reset_n && key_valid && key_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_code <= key_code;
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Press key (r,c) while the previous column is driven; return once kpc reaches column c.
    task automatic arm(input int r, input int c);
        int n;
        n = 0;
        while (kpc !== colpat[(c + 3) % 4] && n < 200) begin tick(); n++; end
        kr = r; kc = c; key_down = 1'b1;
        while (kpc !== colpat[c] && n < 400) begin tick(); n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL arm_timeout key %0d,%0d kpc %b", r, c, kpc); end
    endtask

    task automatic wait_hit(input logic lvl, output int n);
        n = 0;
        while (kphit !== lvl && n < 300) begin tick(); n++; end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; key_ready = 1'b0; key_down = 1'b0; raw_mode = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (kpc !== 4'b0111) begin errors++; $display("FAIL rst_kpc got %b exp 0111", kpc); end
        if (kphit !== 1'b0) begin errors++; $display("FAIL rst_kphit got %b exp 0", kphit); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", key_valid); end
        if (key_code !== 4'h0) begin errors++; $display("FAIL rst_code got %h exp 0", key_code); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun); end
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (kpc !== colpat[(k / 4) % 4]) begin
                errors++; $display("FAIL scan_rotate edge %0d got %b exp %b", k, kpc, colpat[(k / 4) % 4]);
            end
        end
        checks++;
        if (kphit !== 1'b0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL idle_outputs kphit %b valid %b exp 0 0", kphit, key_valid);
        end
    endtask

    task automatic test_random_keys;
        int r, c, n, base;
        for (int it = 0; it < 12; it++) begin
            r = (it == 0) ? 1 : int'($urandom_range(0, 3));
            c = (it == 0) ? 2 : int'($urandom_range(0, 3));
            key_ready = 1'b0;
            base = xfer_cnt;
            arm(r, c);
            wait_hit(1'b1, n);
            checks += 2;
            if (n != LAT) begin errors++; $display("FAIL press_latency key %0d,%0d got %0d exp %0d", r, c, n, LAT); end
            if (key_valid !== 1'b1 || key_code !== codes[r][c]) begin
                errors++; $display("FAIL press_code valid %b got %h exp %h", key_valid, key_code, codes[r][c]);
            end
            repeat ($urandom_range(0, 4)) tick();
            checks++;
            if (key_valid !== 1'b1 || key_code !== codes[r][c]) begin
                errors++; $display("FAIL code_stable valid %b got %h exp %h", key_valid, key_code, codes[r][c]);
            end
            key_ready = 1'b1;
            tick();
            key_ready = 1'b0;
            checks += 2;
            if (key_valid !== 1'b0) begin errors++; $display("FAIL valid_drop got %b exp 0", key_valid); end
            if (xfer_cnt != base + 1 || last_code !== codes[r][c]) begin
                errors++; $display("FAIL xfer xfers %0d exp %0d code %h exp %h", xfer_cnt - base, 1, last_code, codes[r][c]);
            end
            repeat ($urandom_range(0, 12)) tick();
            checks++;
            if (kphit !== 1'b1) begin errors++; $display("FAIL kphit_held got %b exp 1", kphit); end
            key_down = 1'b0;
            key_ready = 1'b1;
            wait_hit(1'b0, n);
            key_ready = 1'b0;
            checks += 2;
            if (n < RLO || n > RHI) begin errors++; $display("FAIL release_time got %0d exp %0d..%0d", n, RLO, RHI); end
            if (xfer_cnt != base + 1) begin errors++; $display("FAIL one_key_per_press got %0d exp 1", xfer_cnt - base); end
        end
    endtask

    task automatic test_overrun;
        int n, base;
        key_ready = 1'b0;
        arm(3, 1);
        wait_hit(1'b1, n);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h0) begin
            errors++; $display("FAIL ovr_first valid %b code %h exp 1 0", key_valid, key_code);
        end
        key_down = 1'b0; wait_hit(1'b0, n);
        arm(0, 3);
        wait_hit(1'b1, n);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h0 || overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_drop valid %b code %h ovr %b exp 1 0 1", key_valid, key_code, overrun);
        end
        key_down = 1'b0; wait_hit(1'b0, n);
        base = xfer_cnt;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || overrun !== 1'b0 || xfer_cnt != base + 1 || last_code !== 4'h0) begin
            errors++; $display("FAIL ovr_clear valid %b ovr %b xfers %0d code %h exp 0 0 1 0",
                               key_valid, overrun, xfer_cnt - base, last_code);
        end
    endtask

    task automatic test_bounce;
        int n, base;
        key_ready = 1'b1;
        base = xfer_cnt;
        arm(0, 0);
        repeat (2 * SD) tick();
        key_down = 1'b0;
        repeat (SD) tick();
        checks++;
        if (kpc !== colpat[1] || kphit !== 1'b0) begin
            errors++; $display("FAIL bounce_resume kpc %b kphit %b exp %b 0", kpc, kphit, colpat[1]);
        end
        repeat (40) tick();
        checks++;
        if (xfer_cnt != base || key_valid !== 1'b0) begin
            errors++; $display("FAIL bounce_nokey xfers %0d valid %b exp 0 0", xfer_cnt - base, key_valid);
        end
        arm(0, 0);
        wait_hit(1'b1, n);
        tick();
        checks++;
        if (n != LAT || xfer_cnt != base + 1 || last_code !== 4'h1) begin
            errors++; $display("FAIL bounce_stable lat %0d xfers %0d code %h exp %0d 1 1", n, xfer_cnt - base, last_code, LAT);
        end
        key_down = 1'b0; wait_hit(1'b0, n);
        key_ready = 1'b0;
    endtask

    task automatic test_invalid;
        int changes;
        logic [3:0] prev;
        logic bad;
        raw_mode = 1'b1; raw_val = 4'b0101;
        changes = 0; bad = 1'b0; prev = kpc;
        repeat (40) begin
            tick();
            if (kpc !== prev) changes++;
            prev = kpc;
            if (kphit !== 1'b0 || key_valid !== 1'b0) bad = 1'b1;
        end
        raw_mode = 1'b0;
        checks++;
        if (changes != 40 / SD || bad) begin
            errors++; $display("FAIL invalid_row col_steps %0d exp %0d outputs_bad %b", changes, 40 / SD, bad);
        end
    endtask

    task automatic test_back_to_back;
        int n, base;
        key_ready = 1'b0;
        arm(2, 0); wait_hit(1'b1, n); key_down = 1'b0; wait_hit(1'b0, n);
        arm(1, 3); wait_hit(1'b1, n);
        checks++;
        if (overrun !== 1'b1 || key_code !== 4'h7) begin
            errors++; $display("FAIL b2b_setup ovr %b code %h exp 1 7", overrun, key_code);
        end
        key_down = 1'b0; wait_hit(1'b0, n);
        arm(3, 2);
        repeat (LAT - 1) tick();
        checks++;
        if (kphit !== 1'b0 || key_valid !== 1'b1 || key_code !== 4'h7) begin
            errors++; $display("FAIL b2b_pre kphit %b valid %b code %h exp 0 1 7", kphit, key_valid, key_code);
        end
        base = xfer_cnt;
        key_ready = 1'b1;
        tick();
        checks += 2;
        if (key_valid !== 1'b1 || key_code !== 4'hE || overrun !== 1'b0 || kphit !== 1'b1) begin
            errors++; $display("FAIL b2b_load valid %b code %h ovr %b kphit %b exp 1 e 0 1",
                               key_valid, key_code, overrun, kphit);
        end
        if (xfer_cnt != base + 1 || last_code !== 4'h7) begin
            errors++; $display("FAIL b2b_xfer xfers %0d code %h exp 1 7", xfer_cnt - base, last_code);
        end
        tick();
        key_ready = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || last_code !== 4'hE) begin
            errors++; $display("FAIL b2b_drain valid %b code %h exp 0 e", key_valid, last_code);
        end
        key_down = 1'b0; wait_hit(1'b0, n);
    endtask

    task automatic test_reset_mid;
        int n, base;
        key_ready = 1'b0;
        arm(2, 1); wait_hit(1'b1, n); key_down = 1'b0; wait_hit(1'b0, n);
        arm(0, 1); wait_hit(1'b1, n);
        checks++;
        if (key_valid !== 1'b1 || overrun !== 1'b1 || key_code !== 4'h8) begin
            errors++; $display("FAIL mid_setup valid %b ovr %b code %h exp 1 1 8", key_valid, overrun, key_code);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (kpc !== 4'b0111 || kphit !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0 || overrun !== 1'b0) begin
            errors++; $display("FAIL async_reset kpc %b kphit %b valid %b code %h ovr %b exp 0111 0 0 0 0",
                               kpc, kphit, key_valid, key_code, overrun);
        end
        @(negedge clk);
        reset_n = 1'b1;
        key_ready = 1'b1;
        base = xfer_cnt;
        wait_hit(1'b1, n);
        tick();
        checks++;
        if (n >= 300 || xfer_cnt != base + 1 || last_code !== 4'h2) begin
            errors++; $display("FAIL reemit wait %0d xfers %0d code %h exp <300 1 2", n, xfer_cnt - base, last_code);
        end
        key_down = 1'b0; wait_hit(1'b0, n);
        key_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_random_keys();
        test_overrun();
        test_bounce();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
